m_sec_display: RTL and testbench
================================

// Module: m_sec_display
// PURPOSE
//  Downstream consumer of the 1 s timer's one-hot sec[9:0] output (bit n set = n seconds).
//  Converts it to units digit, extends it with tens-of-seconds (0-5) and minutes (0-9), and
//  drives a 4-digit multiplexed 7-segment display. Provides a display hold (lap) and a
//  sticky fault flag for a non-one-hot input.
// PARAMETERS
//  SCAN_DIV  50000  clk cycles per digit slot (1 ms at 50 MHz); legal range 2..65535
// PORTS
//  clk       in   1   system clock, rising edge
//  rst       in   1   asynchronous, active-low reset (0 = reset)
//  sec       in   10  one-hot seconds from the timer stage, synchronous to clk
//  hold      in   1   1 = freeze the display; counting continues
//  an        out  4   digit enable, active-high one-hot; an[0] = units ... an[3] = status
//  seg       out  7   segments {g,f,e,d,c,b,a}, active-high
//  tens      out  3   live tens-of-seconds, 0..5
//  mins      out  4   live minutes, 0..9
//  wrap      out  1   one-cycle pulse when 9:59 rolls to 0:00
//  err       out  1   sticky: sec was not one-hot on at least one sampled cycle
// BEHAVIOUR
//  Reset (rst=0, async): sec_q=10'b0000000001, units/tens/mins=0, disp regs=0, scan cnt=0,
//   digit idx=0, err=0, wrap=0 -> an=4'b0001, seg=7'b0111111 ('0').
//  Input sampling: sec_q <= sec every clk. valid = exactly one bit of sec set.
//   valid: units <= index of set bit. Invalid: units holds, err <= 1 (cleared only by reset).
//  Rollover: sec_q[9]=1 and sec[0]=1 and both one-hot in the same cycle -> carry.
//   Any other transition, including skips (e.g. 7->0), gives no carry.
//   Carry: tens+1; at tens=5 tens->0 and mins+1; at mins=9 and tens=5, mins->0 and wrap=1
//   for exactly that cycle. tens/mins/wrap registered; update the cycle after the carry.
//  Display regs (d_units,d_tens,d_mins): load live units/tens/mins each clk while hold=0
//   (one-cycle lag behind live values); retain while hold=1. Releasing hold reloads on the
//   next clk. hold and carry in the same cycle: display keeps pre-carry values.
//  Scan: cnt counts 0..SCAN_DIV-1 and wraps; on cnt=SCAN_DIV-1, idx advances 0->1->2->3->0.
//   an = one-hot(idx), combinational from idx. seg combinational from idx and display regs:
//   idx0 d_units, idx1 d_tens, idx2 d_mins, idx3 blank 7'b0000000, or 'E' 7'b1111001 if err=1.
//  Digit codes gfedcba: 0=0111111 1=0000110 2=1011011 3=1001111 4=1100110 5=1101101
//   6=1111101 7=0000111 8=1111111 9=1101111. Codes >9 cannot occur by construction.
//  Reset mid-operation: all state returns to reset values immediately, regardless of clk.
//  hold is not synchronised inside this block; it must come from a clk-synchronous source.
// TESTING  (SCAN_DIV=4 on bench)
//  1 reset: rst=0 then release, sec=1<<0 -> an=0001 seg=0111111 err=0 wrap=0 tens=0 mins=0.
//  2 count: sec steps 0..9 then 0, each held 8 clks -> units follows 0..9; after 9->0
//   tens=1, mins=0; no wrap; scan shows digit 1 on an=0010 (seg=0000110).
//  3 full roll: drive 59 s, then 9->0 -> tens=0, mins=1; from 9:59 ->0:00 wrap high 1 clk.
//  4 hold: at 0:23 assert hold, advance to 0:31 -> display 3/2/0 retained, tens=3 live;
//   release -> display 1/3/0 after 1 clk.
//  5 fault: sec=10'b0000000011 one clk -> err=1 units unchanged; idx3 seg=1111001; a 9->0
//   step straddling the bad cycle gives no carry; err stays 1 until reset.
//  6 scan timing: idx advances every 4 clks, an sequence 0001,0010,0100,1000,0001;
//   async reset asserted mid-slot -> an=0001 immediately.

Source files
------------

// File: rtl/m_sec_display.sv
// Seconds display stage: one-hot seconds in, units/tens/minutes counted,
// shown on a 4-digit multiplexed 7-segment display with hold and fault flag.
//
// Ports:
//   clk   in  1   system clock, rising edge
//   rst   in  1   asynchronous reset, active low
//   sec   in  10  one-hot seconds from the timer stage (bit n = n seconds)
//   hold  in  1   1 = freeze displayed value, counting continues
//   an    out 4   digit enable, one-hot, an[0]=units .. an[3]=status
//   seg   out 7   segments {g,f,e,d,c,b,a}, active high
//   tens  out 3   live tens of seconds, 0..5
//   mins  out 4   live minutes, 0..9
//   wrap  out 1   one-cycle pulse on 9:59 -> 0:00
//   err   out 1   sticky: sec was seen not one-hot
module m_sec_display #(
   parameter int SCAN_DIV = 50000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [9:0] sec,
   input  logic       hold,
   output logic [3:0] an,
   output logic [6:0] seg,
   output logic [2:0] tens,
   output logic [3:0] mins,
   output logic       wrap,
   output logic       err
);

   localparam logic [15:0] CNT_MAX = 16'(SCAN_DIV - 1);

   logic [9:0]  sec_q;
   logic [3:0]  units;
   logic [3:0]  units_nxt;
   logic        valid;
   logic        carry;
   logic [3:0]  d_units;
   logic [2:0]  d_tens;
   logic [3:0]  d_mins;
   logic [15:0] cnt;
   logic [1:0]  idx;
   logic [3:0]  digit;

   function automatic logic [6:0] seg7(input logic [3:0] d);
      logic [6:0] s;
      unique case (d)
         4'd0:    s = 7'b0111111;
         4'd1:    s = 7'b0000110;
         4'd2:    s = 7'b1011011;
         4'd3:    s = 7'b1001111;
         4'd4:    s = 7'b1100110;
         4'd5:    s = 7'b1101101;
         4'd6:    s = 7'b1111101;
         4'd7:    s = 7'b0000111;
         4'd8:    s = 7'b1111111;
         4'd9:    s = 7'b1101111;
         default: s = 7'b0000000;
      endcase
      return s;
   endfunction

   // one-hot test: nonzero with a single bit set
   always_comb begin
      valid     = (sec != 10'd0) && ((sec & (sec - 10'd1)) == 10'd0);
      units_nxt = units;
      for (int i = 0; i < 10; i++) begin
         if (sec[i]) units_nxt = 4'(i);
      end
      // only a clean 9 -> 0 step carries; skips and faults do not
      carry = valid && sec[0] && (sec_q == 10'b1000000000);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sec_q   <= 10'b0000000001;
         units   <= 4'd0;
         tens    <= 3'd0;
         mins    <= 4'd0;
         wrap    <= 1'b0;
         err     <= 1'b0;
         d_units <= 4'd0;
         d_tens  <= 3'd0;
         d_mins  <= 4'd0;
         cnt     <= 16'd0;
         idx     <= 2'd0;
      end else begin
         sec_q <= sec;
         if (valid) units <= units_nxt;
         else       err   <= 1'b1;

         wrap <= 1'b0;
         if (carry) begin
            if (tens == 3'd5) begin
               tens <= 3'd0;
               if (mins == 4'd9) begin
                  mins <= 4'd0;
                  wrap <= 1'b1;
               end else begin
                  mins <= mins + 4'd1;
               end
            end else begin
               tens <= tens + 3'd1;
            end
         end

         // loads pre-update values, so the display lags live by one clk
         if (!hold) begin
            d_units <= units;
            d_tens  <= tens;
            d_mins  <= mins;
         end

         if (cnt == CNT_MAX) begin
            cnt <= 16'd0;
            idx <= idx + 2'd1;
         end else begin
            cnt <= cnt + 16'd1;
         end
      end
   end

   always_comb begin
      an    = 4'b0001 << idx;
      digit = 4'd0;
      seg   = 7'b0000000;
      unique case (idx)
         2'd0: digit = d_units;
         2'd1: digit = {1'b0, d_tens};
         2'd2: digit = d_mins;
         2'd3: digit = 4'd0;
      endcase
      if (idx == 2'd3) seg = err ? 7'b1111001 : 7'b0000000;
      else             seg = seg7(digit);
   end

endmodule

// File: tb/tb_m_sec_display.sv
// Bench for m_sec_display: directed table, hand sequences and random
// stimulus checked each cycle against a behavioural model.
module tb_m_sec_display;

   localparam int SD = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic [9:0] sec;
   logic       hold;
   logic [3:0] an;
   logic [6:0] seg;
   logic [2:0] tens;
   logic [3:0] mins;
   logic       wrap;
   logic       err;

   int errors = 0;
   int checks = 0;
   bit mon_en = 1'b0;

   logic [6:0] code [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                              7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
   localparam logic [6:0] SEG_E = 7'h79;

   m_sec_display #(.SCAN_DIV(SD)) dut (
      .clk(clk), .rst(rst), .sec(sec), .hold(hold),
      .an(an), .seg(seg), .tens(tens), .mins(mins),
      .wrap(wrap), .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // behavioural model: elapsed tens-of-seconds kept as one number 0..59
   logic [9:0] m_prev;
   int  m_units, m_tm, m_du, m_dtm, m_cyc;
   bit  m_wrap, m_err;

   function automatic bit ok(logic [9:0] s);
      return $countones(s) == 1;
   endfunction

   function automatic int idx_of(logic [9:0] s);
      for (int i = 0; i < 10; i++)
         if (s == (10'd1 << i)) return i;
      return 0;
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_prev <= 10'd1; m_units <= 0; m_tm <= 0;
         m_du <= 0; m_dtm <= 0; m_cyc <= 0;
         m_wrap <= 1'b0; m_err <= 1'b0;
      end else begin
         bit c;
         c = ok(sec) && sec == 10'd1 && m_prev == 10'h200;
         if (ok(sec)) m_units <= idx_of(sec);
         m_err <= m_err | !ok(sec);
         if (!hold) begin
            m_du  <= m_units;
            m_dtm <= m_tm;
         end
         m_wrap <= c && m_tm == 59;
         if (c) m_tm <= (m_tm + 1) % 60;
         m_prev <= sec;
         m_cyc  <= m_cyc + 1;
      end
   end

   task automatic check_model();
      int i;
      logic [6:0] es;
      i = (m_cyc / SD) % 4;
      case (i)
         0: es = code[m_du];
         1: es = code[m_dtm % 6];
         2: es = code[m_dtm / 6];
         default: es = m_err ? SEG_E : 7'h00;
      endcase
      chk("mon_an", 16'(an), 16'(4'b0001 << i));
      chk("mon_seg", 16'(seg), 16'(es));
      chk("mon_tens", 16'(tens), 16'(m_tm % 6));
      chk("mon_mins", 16'(mins), 16'(m_tm / 6));
      chk("mon_wrap", 16'(wrap), 16'(m_wrap));
      chk("mon_err", 16'(err), 16'(m_err));
   endtask

   always @(negedge clk) if (mon_en && rst) check_model();

   task automatic tick(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic read_digit(int i, output logic [6:0] s);
      bit found = 1'b0;
      s = 7'h00;
      for (int k = 0; k < 40 && !found; k++) begin
         @(negedge clk);
         if (an == 4'(1 << i)) begin
            s = seg;
            found = 1'b1;
         end
      end
      chk("digit_timeout", 16'(found), 16'd1);
   endtask

   task automatic carry_once();
      sec = 10'h200; tick(1);
      sec = 10'h001; tick(1);
   endtask

   typedef struct {
      logic [9:0] sec;
      bit         hold;
      int         n;
      int         e_tens;
      int         e_mins;
      bit         e_err;
   } vec_t;

   vec_t vt [$];

   initial begin
      logic [6:0] s;
      int nw;
      for (int k = 0; k < 10; k++)
         vt.push_back('{10'd1 << k, 1'b0, 8, 0, 0, 1'b0});
      vt.push_back('{10'd1, 1'b0, 8, 1, 0, 1'b0});

      sec = 10'd1; hold = 1'b0; rst = 1'b1;
      #1 rst = 1'b0;
      #11;
      chk("rst_an", 16'(an), 16'h1);
      chk("rst_seg", 16'(seg), 16'h3F);
      chk("rst_err", 16'(err), 16'd0);
      chk("rst_wrap", 16'(wrap), 16'd0);
      chk("rst_tens", 16'(tens), 16'd0);
      chk("rst_mins", 16'(mins), 16'd0);
      @(negedge clk) rst = 1'b1;
      mon_en = 1'b1;
      tick(1);

      foreach (vt[j]) begin
         sec = vt[j].sec; hold = vt[j].hold;
         tick(vt[j].n);
         chk("tbl_tens", 16'(tens), 16'(vt[j].e_tens));
         chk("tbl_mins", 16'(mins), 16'(vt[j].e_mins));
         chk("tbl_err", 16'(err), 16'(vt[j].e_err));
      end
      read_digit(1, s);
      chk("count_d1", 16'(s), 16'h06);

      tick(1);
      repeat (5) carry_once();
      tick(1);
      chk("roll_tens", 16'(tens), 16'd0);
      chk("roll_mins", 16'(mins), 16'd1);
      repeat (53) carry_once();
      tick(1);
      chk("959_tens", 16'(tens), 16'd5);
      chk("959_mins", 16'(mins), 16'd9);
      sec = 10'h200; tick(1);
      sec = 10'h001;
      nw = 0;
      repeat (4) begin
         @(negedge clk);
         if (wrap) nw++;
      end
      chk("wrap_pulses", 16'(nw), 16'd1);
      chk("wrap_tens", 16'(tens), 16'd0);
      chk("wrap_mins", 16'(mins), 16'd0);

      tick(1);
      repeat (2) carry_once();
      sec = 10'd1 << 3; tick(3);
      hold = 1'b1; tick(1);
      for (int k = 4; k < 10; k++) begin
         sec = 10'd1 << k; tick(1);
      end
      sec = 10'd1; tick(1);
      sec = 10'd2; tick(2);
      chk("hold_tens", 16'(tens), 16'd3);
      read_digit(0, s); chk("hold_d0", 16'(s), 16'(code[3]));
      read_digit(1, s); chk("hold_d1", 16'(s), 16'(code[2]));
      read_digit(2, s); chk("hold_d2", 16'(s), 16'(code[0]));
      tick(1);
      hold = 1'b0; tick(1);
      read_digit(0, s); chk("rel_d0", 16'(s), 16'(code[1]));
      read_digit(1, s); chk("rel_d1", 16'(s), 16'(code[3]));
      read_digit(2, s); chk("rel_d2", 16'(s), 16'(code[0]));

      tick(1);
      sec = 10'h200; tick(1);
      sec = 10'h003; tick(1);
      chk("fault_err", 16'(err), 16'd1);
      read_digit(0, s); chk("fault_units", 16'(s), 16'(code[9]));
      read_digit(3, s); chk("fault_E", 16'(s), 16'(SEG_E));
      tick(1);
      sec = 10'h001; tick(2);
      chk("fault_nocarry", 16'(tens), 16'd3);
      tick(10);
      chk("fault_sticky", 16'(err), 16'd1);

      @(negedge clk) rst = 1'b0;
      @(negedge clk) rst = 1'b1;
      for (int k = 1; k <= 17; k++) begin
         @(negedge clk);
         chk("scan_an", 16'(an), 16'(4'b0001 << ((k / SD) % 4)));
      end
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      chk("async_an", 16'(an), 16'h1);
      chk("async_seg", 16'(seg), 16'h3F);
      chk("async_err", 16'(err), 16'd0);
      @(negedge clk) rst = 1'b1;
      tick(1);

      for (int n = 0; n < 1500; n++) begin
         int r;
         r = $urandom_range(0, 99);
         if (n > 750 && r < 2) sec = 10'($urandom_range(0, 1023));
         else if (r < 30) sec = 10'h200;
         else if (r < 60) sec = 10'h001;
         else sec = 10'd1 << $urandom_range(0, 9);
         if ($urandom_range(0, 7) == 0) hold = ~hold;
         if ($urandom_range(0, 299) == 0) begin
            #2 rst = 1'b0;
            #1 chk("rnd_async_an", 16'(an), 16'h1);
            @(negedge clk) rst = 1'b1;
         end
         tick(1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
